// File: rtl/mem_rmw_pkg.sv
// Shared definitions for the read-modify-write memory sequencer.
//   state_t      : sequencer FSM states
//   BE_FULL/NONE : byte-enable patterns that bypass the read phase
//   RD_LAT_MIN/MAX : legal range of the RD_LATENCY parameter
//   req_t        : request fields latched at accept
package mem_rmw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WRITE,
        RESP
    } state_t;

    localparam logic [3:0] BE_FULL = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    // Counter must hold RD_LAT_MAX.
    localparam int CNT_W      = 3;

    localparam int NUM_LANES  = 4;
    localparam int LANE_W     = 8;

    typedef struct packed {
        logic        write;
        logic [29:0] word_addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_rmw_sequencer_merge.sv
// Byte-lane merge for partial stores: each lane takes the store byte when
// its enable is set, otherwise keeps the byte read from memory.
//   be     : lane enables (be[3] = bits 31:24)
//   wdata  : lane-aligned store data
//   rdata  : word read from memory
//   merged : word to write back
module byte_lane_merge
    import mem_rmw_pkg::*;
(
    input  logic [NUM_LANES-1:0]        be,
    input  logic [NUM_LANES*LANE_W-1:0] wdata,
    input  logic [NUM_LANES*LANE_W-1:0] rdata,
    output logic [NUM_LANES*LANE_W-1:0] merged
);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign merged[LANE_W*i +: LANE_W] = be[i] ? wdata[LANE_W*i +: LANE_W]
                                                  : rdata[LANE_W*i +: LANE_W];
    end

endmodule

// File: rtl/mem_rmw_sequencer.sv
// Memory-stage access sequencer. Full-word stores go straight to memory,
// byte-enable-none stores complete with no access, loads and partial stores
// read the word first; partial stores then merge and write the word back.
//   CLK, RESET            : clock, async active-high reset
//   req_valid/ready       : request handshake (ready only in IDLE)
//   req_write/addr/be/wdata : request fields
//   resp_valid/rdata      : one-cycle completion pulse, load data
//   busy                  : pipeline stall, high outside IDLE
//   dm_*                  : data memory port, read data RD_LATENCY cycles
//                           after the dm_read cycle
// RD_LATENCY must be within RD_LAT_MIN..RD_LAT_MAX.
module mem_rmw_sequencer
    import mem_rmw_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        busy,
    output logic [31:0] dm_addr,
    output logic        dm_read,
    output logic        dm_write,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    req_t               req_q, req_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        merged;

    // Address byte offset is irrelevant: all accesses are full words.
    logic [1:0]         unused_addr_lsb;
    assign unused_addr_lsb = req_addr[1:0];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d = '{write:     req_write,
                              word_addr: req_addr[31:2],
                              be:        req_be,
                              wdata:     req_wdata};
                    if (req_write && req_be == BE_FULL)
                        state_d = WRITE;
                    else if (req_write && req_be == BE_NONE)
                        state_d = RESP;
                    else
                        state_d = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                cnt_d   = CNT_W'(RD_LATENCY);
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // Counter hits 0 on this edge: read data is valid now.
                if (cnt_q == CNT_W'(1)) begin
                    rdata_d = dm_rdata;
                    state_d = req_q.write ? WRITE : RESP;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // For a full store be is all ones, so the merge passes wdata straight
    // through and one datapath serves both write flavours.
    byte_lane_merge u_merge (
        .be     (req_q.be),
        .wdata  (req_q.wdata),
        .rdata  (rdata_q),
        .merged (merged)
    );

    // All outputs decode from registered state only.
    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = (state_q == RESP && !req_q.write) ? rdata_q : '0;
    assign dm_read    = (state_q == RD_ISSUE);
    assign dm_write   = (state_q == WRITE);
    assign dm_wdata   = (state_q == WRITE) ? merged : '0;
    assign dm_addr    = (state_q == RD_ISSUE || state_q == RD_WAIT || state_q == WRITE)
                        ? {req_q.word_addr, 2'b00} : '0;

endmodule

// File: tb/tb_mem_rmw_sequencer.sv
// Two sequencers (RD_LATENCY 1 and 3) driven in lockstep by the same
// directed vectors. Expected responses are queued per instance at issue and
// checked by a negedge monitor.
module tb_mem_rmw_sequencer;

    localparam int K_LOAD = 0, K_FULL = 1, K_PART = 2, K_NONE = 3;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] mem;
        int          kind;
        logic [31:0] exp_addr;
        logic [31:0] exp_rdata;
        logic [31:0] exp_wdata;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        int          resp_cyc;
        bit          rd;
        int          rd_cyc;
        logic [31:0] addr;
        bit          wr;
        int          wr_cyc;
        logic [31:0] wdata;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic [31:0] mem_word;

    logic [1:0]  rr, rv, bsy, dmr, dmw;
    logic [31:0] rdata_w [2];
    logic [31:0] dm_addr_w [2];
    logic [31:0] dm_wdata_w [2];
    logic [31:0] dm_rdata_w [2];
    logic [31:0] rd_pipe [2][4];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q [2][$];
    bit   rd_seen [2];
    bit   wr_seen [2];
    vec_t vecs [9];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    mem_rmw_sequencer #(.RD_LATENCY(1)) u_dut0 (
        .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_ready(rr[0]),
        .req_write(req_write), .req_addr(req_addr), .req_be(req_be),
        .req_wdata(req_wdata), .resp_valid(rv[0]), .resp_rdata(rdata_w[0]),
        .busy(bsy[0]), .dm_addr(dm_addr_w[0]), .dm_read(dmr[0]),
        .dm_write(dmw[0]), .dm_wdata(dm_wdata_w[0]), .dm_rdata(dm_rdata_w[0])
    );

    mem_rmw_sequencer #(.RD_LATENCY(3)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_ready(rr[1]),
        .req_write(req_write), .req_addr(req_addr), .req_be(req_be),
        .req_wdata(req_wdata), .resp_valid(rv[1]), .resp_rdata(rdata_w[1]),
        .busy(bsy[1]), .dm_addr(dm_addr_w[1]), .dm_read(dmr[1]),
        .dm_write(dmw[1]), .dm_wdata(dm_wdata_w[1]), .dm_rdata(dm_rdata_w[1])
    );

    // Memory model: word is valid only in the cycle RD_LATENCY after dm_read,
    // garbage otherwise, so an early or late capture is visible.
    always @(posedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            rd_pipe[k][0] <= dmr[k] ? mem_word : 32'hBAD0_BAD0;
            for (int j = 1; j < 4; j++) rd_pipe[k][j] <= rd_pipe[k][j-1];
        end
    end
    assign dm_rdata_w[0] = rd_pipe[0][0];
    assign dm_rdata_w[1] = rd_pipe[1][2];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [RD_LATENCY=%0d] cyc=%0d got %h expected %h", name, lat_of(k), cyc, act, exp);
        end
    endtask

    task automatic bad(input string name, input int k);
        n_cmp++;
        n_bad++;
        $display("FAIL %s [RD_LATENCY=%0d] cyc=%0d got event expected none", name, lat_of(k), cyc);
    endtask

    task automatic mon(input int k);
        exp_t e;
        if (dmr[k] && dmw[k]) bad("rd_wr_overlap", k);
        if (rr[k]) chk("idle_dm_addr", k, dm_addr_w[k], 32'h0);
        if (dmr[k]) begin
            if (q[k].size() == 0 || !q[k][0].rd || rd_seen[k]) bad("unexpected_read", k);
            else begin
                chk("rd_addr", k, dm_addr_w[k], q[k][0].addr);
                chk("rd_cycle", k, cyc, q[k][0].rd_cyc);
                rd_seen[k] = 1'b1;
            end
        end
        if (dmw[k]) begin
            if (q[k].size() == 0 || !q[k][0].wr || wr_seen[k]) bad("unexpected_write", k);
            else begin
                chk("wr_addr", k, dm_addr_w[k], q[k][0].addr);
                chk("wr_data", k, dm_wdata_w[k], q[k][0].wdata);
                chk("wr_cycle", k, cyc, q[k][0].wr_cyc);
                wr_seen[k] = 1'b1;
            end
        end
        if (rv[k]) begin
            if (q[k].size() == 0) bad("unexpected_resp", k);
            else begin
                e = q[k].pop_front();
                chk("resp_rdata", k, rdata_w[k], e.rdata);
                chk("resp_cycle", k, cyc, e.resp_cyc);
                chk("read_done", k, 32'(rd_seen[k]), 32'(e.rd));
                chk("write_done", k, 32'(wr_seen[k]), 32'(e.wr));
                rd_seen[k] = 1'b0;
                wr_seen[k] = 1'b0;
            end
        end
    endtask

    always @(negedge CLK) begin
        if (!RESET) for (int k = 0; k < 2; k++) mon(k);
    end

    // Observation offsets from the drive cycle c (accept edge is c+1).
    function automatic exp_t make_exp(input vec_t v, input int c, input int L);
        exp_t e;
        e.rdata  = v.exp_rdata;
        e.addr   = v.exp_addr;
        e.wdata  = v.exp_wdata;
        e.rd     = (v.kind == K_LOAD || v.kind == K_PART);
        e.rd_cyc = c + 1;
        e.wr     = (v.kind == K_FULL || v.kind == K_PART);
        e.wr_cyc = (v.kind == K_FULL) ? c + 1 : c + 2 + L;
        case (v.kind)
            K_LOAD:  e.resp_cyc = c + 2 + L;
            K_FULL:  e.resp_cyc = c + 2;
            K_PART:  e.resp_cyc = c + 3 + L;
            default: e.resp_cyc = c + 1;
        endcase
        return e;
    endfunction

    task automatic check_reset(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_req_ready"}, k, 32'(rr[k]), 32'h1);
            chk({tag, "_busy"}, k, 32'(bsy[k]), 32'h0);
            chk({tag, "_resp_valid"}, k, 32'(rv[k]), 32'h0);
            chk({tag, "_resp_rdata"}, k, rdata_w[k], 32'h0);
            chk({tag, "_dm_read"}, k, 32'(dmr[k]), 32'h0);
            chk({tag, "_dm_write"}, k, 32'(dmw[k]), 32'h0);
            chk({tag, "_dm_addr"}, k, dm_addr_w[k], 32'h0);
            chk({tag, "_dm_wdata"}, k, dm_wdata_w[k], 32'h0);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!(rr[0] && rr[1]) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) bad("ready_timeout", 0);
    endtask

    task automatic drive(input vec_t v);
        int c;
        wait_ready();
        mem_word  = v.mem;
        req_write = v.wr;
        req_addr  = v.addr;
        req_be    = v.be;
        req_wdata = v.wdata;
        req_valid = 1'b1;
        c = cyc;
        for (int k = 0; k < 2; k++) q[k].push_back(make_exp(v, c, lat_of(k)));
    endtask

    task automatic send(input vec_t v);
        drive(v);
        @(negedge CLK);
        // req_valid kept high while busy must not start a second access.
        for (int h = 0; h < v.hold; h++) begin
            for (int k = 0; k < 2; k++) begin
                chk("ready_while_busy", k, 32'(rr[k]), 32'h0);
                chk("busy_while_busy", k, 32'(bsy[k]), 32'h1);
            end
            @(negedge CLK);
        end
        req_valid = 1'b0;
    endtask

    initial begin
        int n;
        vec_t va;
        RESET = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_be = '0; req_wdata = '0; mem_word = '0;
        //              wr    addr          be       wdata         mem           kind    exp_addr      exp_rdata     exp_wdata     hold
        vecs[0] = '{1'b0, 32'h0000_1006, 4'b1111, 32'h0000_0000, 32'h1122_3344, K_LOAD, 32'h0000_1004, 32'h1122_3344, 32'h0000_0000, 0};
        vecs[1] = '{1'b1, 32'h0000_1005, 4'b0100, 32'h00AA_0000, 32'h1122_3344, K_PART, 32'h0000_1004, 32'h0000_0000, 32'h11AA_3344, 0};
        vecs[2] = '{1'b1, 32'h0000_2000, 4'b1111, 32'hDEAD_BEEF, 32'h7777_7777, K_FULL, 32'h0000_2000, 32'h0000_0000, 32'hDEAD_BEEF, 0};
        vecs[3] = '{1'b1, 32'h0000_3002, 4'b1100, 32'hCAFE_0000, 32'h0102_0304, K_PART, 32'h0000_3000, 32'h0000_0000, 32'hCAFE_0304, 3};
        vecs[4] = '{1'b1, 32'h0000_4000, 4'b0000, 32'h1234_5678, 32'h6666_6666, K_NONE, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0};
        vecs[5] = '{1'b0, 32'h0000_3FFF, 4'b1111, 32'h0000_0000, 32'hA5A5_5A5A, K_LOAD, 32'h0000_3FFC, 32'hA5A5_5A5A, 32'h0000_0000, 0};
        vecs[6] = '{1'b1, 32'h0000_5003, 4'b0001, 32'h0000_00EE, 32'hFFFF_FFFF, K_PART, 32'h0000_5000, 32'h0000_0000, 32'hFFFF_FFEE, 0};
        vecs[7] = '{1'b1, 32'h0000_6000, 4'b1010, 32'h1200_3400, 32'hAABB_CCDD, K_PART, 32'h0000_6000, 32'h0000_0000, 32'h12BB_34DD, 0};
        vecs[8] = '{1'b0, 32'h0000_7008, 4'b1111, 32'h0000_0000, 32'h55AA_1234, K_LOAD, 32'h0000_7008, 32'h55AA_1234, 32'h0000_0000, 0};

        repeat (2) @(negedge CLK);
        check_reset("rst_init");
        RESET = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 8; i++) send(vecs[i]);

        // Reset while both instances sit in RD_WAIT of a partial store.
        va = '{1'b1, 32'h0000_8000, 4'b0011, 32'h0000_BEEF, 32'h9999_9999, K_PART, 32'h0000_8000, 32'h0000_0000, 32'h9999_BEEF, 0};
        drive(va);
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        #1 RESET = 1'b1;
        #1 check_reset("rst_async");
        for (int k = 0; k < 2; k++) begin
            q[k].delete();
            rd_seen[k] = 1'b0;
            wr_seen[k] = 1'b0;
        end
        repeat (2) begin
            @(negedge CLK);
            check_reset("rst_hold");
        end
        RESET = 1'b0;
        @(negedge CLK);

        send(vecs[8]);

        n = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        repeat (5) @(negedge CLK);
        for (int k = 0; k < 2; k++) chk("queue_drained", k, 32'(q[k].size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got no finish expected finish", cyc);
        $fatal(1);
    end

endmodule

// File: doc/mem_rmw_sequencer.md
MEM_RMW_SEQUENCER -- requirements
Module: mem_rmw_sequencer

Interface
REQ-001 Parameter RD_LATENCY, default 1, sets the cycles from dm_read assertion to valid dm_rdata; legal values are 1..4.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 CLK  in  1  clock; all state updates on rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  MEM stage presents an access.
REQ-006 req_ready  out  1  block can accept; high only in IDLE.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  32  byte address; bits [1:0] ignored.
REQ-009 req_be  in  4  byte enables, big-endian: be[3]=bits 31:24 (offset 0) through be[0]=bits 7:0 (offset 3).
REQ-010 req_wdata  in  32  store data, already lane-aligned.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  loaded word on load completion, else 0.
REQ-013 busy  out  1  high in any state other than IDLE; drives the pipeline stall.
REQ-014 dm_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
REQ-015 dm_read  out  1  single-cycle read strobe.
REQ-016 dm_write  out  1  single-cycle full-word write strobe.
REQ-017 dm_wdata  out  32  word to write.
REQ-018 dm_rdata  in  32  memory read data, valid RD_LATENCY cycles after dm_read.

Function
REQ-019 The FSM shall have the states IDLE, RD_ISSUE, RD_WAIT, WRITE and RESP, encoded in the shared package.
REQ-020 In IDLE, req_valid shall be accepted at the edge and addr, be, wdata and write shall be latched; req_valid is ignored in every other state.
REQ-021 An accepted store with be=4'b1111 shall go to WRITE; one with be=4'b0000 shall go to RESP with no memory access; all other accepted requests shall go to RD_ISSUE.
REQ-022 RD_ISSUE shall assert dm_read for exactly one cycle, load a countdown counter with RD_LATENCY, and go to RD_WAIT.
REQ-023 RD_WAIT shall decrement the counter each cycle and, on the cycle the counter reaches 0, capture dm_rdata, which is RD_LATENCY cycles after the dm_read cycle.
REQ-024 After capture, a load shall go to RESP; a partial store shall form merged[8i+7:8i] = be[i] ? wdata : rdata for each lane i and go to WRITE.
REQ-025 WRITE shall assert dm_write for exactly one cycle with dm_wdata equal to the latched wdata (full store) or the merged word (partial store), then go to RESP.
REQ-026 RESP shall pulse resp_valid for one cycle and return to IDLE; resp_rdata shall be the captured word for loads and 0 for stores.
REQ-027 Latency from the accept edge T to resp_valid:
- full store: T+2
- be=0 store: T+1
- load: T+2+RD_LATENCY
- partial store: T+3+RD_LATENCY
REQ-028 dm_read and dm_write shall never be high in the same cycle, and both shall be decoded from the state register only, glitch-free.
REQ-029 dm_addr shall hold the latched aligned address from RD_ISSUE through WRITE, and shall be 0 in IDLE.
REQ-030 Back-to-back operation: req_ready rises the cycle after resp_valid, so the maximum rate is one access per (latency+1) cycles.

Reset
REQ-031 RESET shall force the state to IDLE, the counter to 0 and all latched fields to 0 immediately, without waiting for a clock edge.
REQ-032 While RESET is high, outputs shall be req_ready=1, busy=0, resp_valid=0, resp_rdata=0, dm_read=0, dm_write=0, dm_addr=0, dm_wdata=0.
REQ-033 Reset during RD_WAIT or WRITE shall abandon the access with no further dm_write and no resp_valid; a read already issued is discarded.

Structure
REQ-034 Package mem_rmw_pkg shall hold:
- the state enumeration
- the BE_FULL/BE_NONE constants
- the RD_LATENCY legal range
REQ-035 Lane merging shall live in one combinational sub-module, byte_lane_merge (inputs be, wdata, rdata; output merged).

Verification
REQ-036 Load, RD_LATENCY=1, addr 0x1006, memory word 0x11223344 -> dm_read with dm_addr=0x1004 at T+1; resp_valid at T+3 with resp_rdata=0x11223344.
REQ-037 SB store, be=4'b0100, wdata=0x00AA0000, memory 0x11223344 -> one dm_read, then dm_write with dm_wdata=0x11AA3344 at T+3; resp_valid at T+4.
REQ-038 Full store, be=4'b1111, wdata=0xDEADBEEF -> no dm_read; dm_write at T+1; resp_valid at T+2.
REQ-039 RD_LATENCY=3, SWR-style be=4'b1100, wdata=0xCAFE0000, memory 0x01020304 -> dm_wdata=0xCAFE0304 at T+5; req_valid held high during busy is not re-accepted.
REQ-040 RESET asserted mid-RD_WAIT of a partial store -> dm_write stays 0, no resp_valid, req_ready=1 asynchronously; the next request completes normally.
REQ-041 Store with be=4'b0000 -> no dm_read or dm_write; resp_valid at T+1 with resp_rdata=0.
